// File: rtl/alu_muldiv_sequencer.sv
// Iterative 32x32 multiply / 32/32 restoring divide that borrows the shared ALU for 32 cycles.
// Optional signed operation is enabled by defining MULDIV_SIGNED_EN; op[1] is ignored otherwise.
module alu_muldiv_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic        done,
    output logic [31:0] resultLo,
    output logic [31:0] resultHi,
    output logic [31:0] aluInA,
    output logic [31:0] aluInB,
    output logic [3:0]  aluCode,
    input  logic [31:0] aluOut
);

    localparam logic [3:0] ALU_CODE_ADD = 4'b0010;
    localparam logic [3:0] ALU_CODE_SUB = 4'b0110;
    localparam logic [5:0] LAST_ITER    = 6'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [5:0]  cnt_reg, cnt_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;
    logic [31:0] operand_reg, operand_next;
    logic        is_div_reg, is_div_next;
    logic        neg_main_reg, neg_main_next;
    logic        neg_rem_reg, neg_rem_next;
    logic [31:0] result_lo_reg, result_lo_next;
    logic [31:0] result_hi_reg, result_hi_next;

    logic        signed_req;
`ifdef MULDIV_SIGNED_EN
    assign signed_req = op[1];
`else
    logic unused_op_sign;
    assign signed_req     = 1'b0;
    assign unused_op_sign = op[1];
`endif

    // Operand magnitudes and sign bookkeeping captured at start.
    logic        sign_a, sign_b, fix_en;
    logic [31:0] mag_a, mag_b;

    always_comb begin
        sign_a = signed_req & srcA[31];
        sign_b = signed_req & srcB[31];
        mag_a  = sign_a ? (~srcA + 32'd1) : srcA;
        mag_b  = sign_b ? (~srcB + 32'd1) : srcB;
        // Division by zero keeps the raw unsigned result.
        fix_en = signed_req & ~(op[0] & (srcB == 32'd0));
    end

    // One iteration step using the borrowed ALU.
    logic [32:0] sh;
    logic        carry, ge;
    logic [31:0] step_hi, step_lo;

    always_comb begin
        sh      = {hi_reg, lo_reg[31]};
        carry   = (aluOut < hi_reg);
        ge      = sh[32] | (sh[31:0] >= operand_reg);
        aluCode = ALU_CODE_ADD;
        aluInA  = 32'd0;
        aluInB  = 32'd0;
        if (state_reg == RUN) begin
            if (is_div_reg) begin
                aluCode = ALU_CODE_SUB;
                aluInA  = sh[31:0];
                aluInB  = operand_reg;
            end else begin
                aluCode = ALU_CODE_ADD;
                aluInA  = hi_reg;
                aluInB  = lo_reg[0] ? operand_reg : 32'd0;
            end
        end
        if (is_div_reg) begin
            step_hi = ge ? aluOut : sh[31:0];
            step_lo = {lo_reg[30:0], ge};
        end else begin
            step_hi = {carry, aluOut[31:1]};
            step_lo = {aluOut[0], lo_reg[31:1]};
        end
    end

    // Sign correction applied on the final load, so latency is unchanged.
    logic [63:0] prod_fixed;
    logic [31:0] quot_fixed, rem_fixed;

    always_comb begin
        prod_fixed = neg_main_reg ? (~{step_hi, step_lo} + 64'd1) : {step_hi, step_lo};
        quot_fixed = neg_main_reg ? (~step_lo + 32'd1) : step_lo;
        rem_fixed  = neg_rem_reg  ? (~step_hi + 32'd1) : step_hi;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 6'd0;
            hi_reg        <= 32'd0;
            lo_reg        <= 32'd0;
            operand_reg   <= 32'd0;
            is_div_reg    <= 1'b0;
            neg_main_reg  <= 1'b0;
            neg_rem_reg   <= 1'b0;
            result_lo_reg <= 32'd0;
            result_hi_reg <= 32'd0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            hi_reg        <= hi_next;
            lo_reg        <= lo_next;
            operand_reg   <= operand_next;
            is_div_reg    <= is_div_next;
            neg_main_reg  <= neg_main_next;
            neg_rem_reg   <= neg_rem_next;
            result_lo_reg <= result_lo_next;
            result_hi_reg <= result_hi_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        hi_next        = hi_reg;
        lo_next        = lo_reg;
        operand_next   = operand_reg;
        is_div_next    = is_div_reg;
        neg_main_next  = neg_main_reg;
        neg_rem_next   = neg_rem_reg;
        result_lo_next = result_lo_reg;
        result_hi_next = result_hi_reg;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next    = RUN;
                    cnt_next      = 6'd0;
                    hi_next       = 32'd0;
                    is_div_next   = op[0];
                    lo_next       = op[0] ? mag_a : mag_b;
                    operand_next  = op[0] ? mag_b : mag_a;
                    neg_main_next = fix_en & (sign_a ^ sign_b);
                    neg_rem_next  = fix_en & sign_a & op[0];
                end
            end
            RUN: begin
                hi_next  = step_hi;
                lo_next  = step_lo;
                cnt_next = cnt_reg + 6'd1;
                if (cnt_reg == LAST_ITER) begin
                    state_next = DONE;
                    if (is_div_reg) begin
                        result_lo_next = quot_fixed;
                        result_hi_next = rem_fixed;
                    end else begin
                        result_lo_next = prod_fixed[31:0];
                        result_hi_next = prod_fixed[63:32];
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == DONE);
    assign resultLo = result_lo_reg;
    assign resultHi = result_hi_reg;

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Directed bench for alu_muldiv_sequencer with a behavioural model of the shared ALU.
module tb_alu_muldiv_sequencer;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srcA, srcB;
    logic        busy, done;
    logic [31:0] resultLo, resultHi;
    logic [31:0] aluInA, aluInB;
    logic [3:0]  aluCode;
    logic [31:0] aluOut;

    int checks   = 0;
    int failures = 0;

    alu_muldiv_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .srcA     (srcA),
        .srcB     (srcB),
        .busy     (busy),
        .done     (done),
        .resultLo (resultLo),
        .resultHi (resultHi),
        .aluInA   (aluInA),
        .aluInB   (aluInB),
        .aluCode  (aluCode),
        .aluOut   (aluOut)
    );

    always #5 clk = ~clk;

    // Shared execute-stage ALU: combinational add/subtract.
    assign aluOut = (aluCode == ALU_SUB) ? (aluInA - aluInB) : (aluInA + aluInB);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi, input int poke_cyc);
        int cyc;
        int busy_cnt;
        @(negedge clk);
        start = 1'b1; op = o; srcA = a; srcB = b;
        @(negedge clk);
        start = 1'b0; op = ~o; srcA = ~a; srcB = b ^ 32'h5A5A_5A5A;
        cyc = 1;
        busy_cnt = 0;
        if (o[1] == 1'b0) begin
            check({tag, "_code"}, {60'd0, aluCode}, {60'd0, (o[0] ? ALU_SUB : ALU_ADD)});
            check({tag, "_inb"}, {32'd0, aluInB}, {32'd0, (o[0] ? b : (b[0] ? a : 32'd0))});
        end
        while (done !== 1'b1 && cyc < 100) begin
            busy_cnt += int'(busy);
            start = (cyc == poke_cyc);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(cyc), 64'd33);
        check({tag, "_busycycles"}, 64'(busy_cnt + int'(busy)), 64'd33);
        check({tag, "_lo"}, {32'd0, resultLo}, {32'd0, exp_lo});
        check({tag, "_hi"}, {32'd0, resultHi}, {32'd0, exp_hi});
        $display("txn %s op=%b a=%h b=%h lo=%h hi=%h cycles=%0d", tag, o, a, b, resultLo, resultHi, cyc);
        @(negedge clk);
        check({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_idle_done"}, {63'd0, done}, 64'd0);
        check({tag, "_hold"}, {resultHi, resultLo}, {exp_hi, exp_lo});
    endtask

    task automatic reset_mid_run();
        int cyc;
        int done_cnt;
        @(negedge clk);
        start = 1'b1; op = 2'b00; srcA = 32'hFFFF_FFFF; srcB = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstrun_busy", {63'd0, busy}, 64'd0);
        check("rstrun_done", {63'd0, done}, 64'd0);
        check("rstrun_results", {resultHi, resultLo}, 64'd0);
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            done_cnt += int'(done);
        end
        check("rstrun_nodone", 64'(done_cnt), 64'd0);
        $display("txn rst_mid_run busy=%b lo=%h hi=%h", busy, resultLo, resultHi);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; srcA = 32'd0; srcB = 32'd0;
        repeat (3) @(negedge clk);
        // Reset and start together: reset wins.
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_results", {resultHi, resultLo}, 64'd0);
        check("reset_code", {60'd0, aluCode}, {60'd0, ALU_ADD});
        check("reset_alu_in", {aluInA, aluInB}, 64'd0);
        @(negedge clk);
        check("reset_start_ignored", {63'd0, busy}, 64'd0);

        run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 32'd42, 32'd0, -1);
        run_op("mul_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, -1);
        run_op("mul_poke", 2'b00, 32'h1234_5678, 32'h10, 32'h2345_6780, 32'h1, 10);
        run_op("div_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 32'd2, -1);
        run_op("div_sh32", 2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 10);
        run_op("div_by0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, -1);
`ifdef MULDIV_SIGNED_EN
        run_op("smul_m3x4", 2'b10, 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFF4, 32'hFFFF_FFFF, -1);
        run_op("sdiv_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, -1);
        run_op("sdiv_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, -1);
`else
        run_op("smul_m3x4", 2'b10, 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFF4, 32'h0000_0003, -1);
        run_op("sdiv_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'h0000_0001, -1);
        run_op("sdiv_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, -1);
`endif
        reset_mid_run();
        run_op("mul_after_rst", 2'b00, 32'd7, 32'd6, 32'd42, 32'd0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_sequencer.md
# alu_muldiv_sequencer

Iterative multiply/divide controller for the pipeline processor's execute stage. It borrows the existing 32-bit ALU through a dedicated operand/code port and runs 32 shift-add or restoring-subtract iterations. It produces a 64-bit product, or a quotient and remainder, with a start/busy/done handshake. Stall logic uses `busy` to hold the pipeline while the sequencer owns the ALU.

## Interface
- No parameters. Widths come from `DataPath` (32 bit) and `ALUCodePath` in Types.v.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request. Accepted only in IDLE.
- `op`  in  2  `op[0]`: 0 = multiply, 1 = divide. `op[1]`: signed (only with `MULDIV_SIGNED_EN`).
- `srcA`  in  32  multiplicand / dividend.
- `srcB`  in  32  multiplier / divisor.
- `busy`  out  1  sequencer owns the ALU; pipeline must stall.
- `done`  out  1  one-cycle pulse; results valid.
- `resultLo`  out  32  product[31:0] / quotient.
- `resultHi`  out  32  product[63:32] / remainder.
- `aluInA`, `aluInB`  out  32  operands driven to the shared ALU.
- `aluCode`  out  `ALUCodePath`  `ALU_CODE_ADD` or `ALU_CODE_SUB`.
- `aluOut`  in  32  ALU result, combinational, same cycle.

## Operation
- States: IDLE → RUN (32 cycles) → DONE (1 cycle) → IDLE.
- IDLE with `start`=1: latch operands, clear the 6-bit iteration counter, go to RUN. `start` is ignored in RUN and DONE.
- Multiply:
  - Registers: hi = 0, lo = multiplier.
  - ALU drive: `aluCode`=ADD, `aluInA`=hi, `aluInB` = lo[0] ? multiplicand : 0.
  - carry = (`aluOut` < hi), unsigned, computed locally.
  - Update: {hi,lo} ← {carry, `aluOut`, lo[31:1]}.
- Divide (restoring):
  - Registers: rem = 0, q = dividend.
  - sh = {rem, q[31]}, 33 bits.
  - ALU drive: `aluCode`=SUB, `aluInA`=sh[31:0], `aluInB`=divisor.
  - ge = sh[32] | (sh[31:0] ≥ divisor), unsigned.
  - Update: rem ← ge ? `aluOut` : sh[31:0]; q ← {q[30:0], ge}.
- Divide by zero needs no special case. The algorithm naturally yields quotient 0xFFFFFFFF and remainder = dividend.
- RUN → DONE after iteration 32. On that edge load `resultLo`/`resultHi`; they hold until the next RUN→DONE.
- IDLE/DONE ALU drive: `aluCode`=ADD, both operands 0.
- Reset values: `busy`=0, `done`=0, `resultLo`=0, `resultHi`=0, state IDLE.

## Timing
- `start` sampled in cycle N. RUN occupies N+1..N+32. `done`=1 in N+33. Next `start` is accepted at N+34 at the earliest.
- `busy`=1 in N+1..N+33 inclusive, and 0 in IDLE.
- `rst` during RUN or DONE: IDLE next cycle, no `done` pulse, results cleared to 0.
- `rst` and `start` in the same cycle: reset wins.
- Operand inputs may change after the start cycle without effect.

## Configuration
- `MULDIV_SIGNED_EN` defined:
  - With `op[1]`=1, operands are converted to magnitudes at start, and signs are recorded.
  - Product is 64-bit negated if the signs differ.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Divisor 0 bypasses correction.
  - −2³¹ / −1 gives quotient 0x80000000, remainder 0.
  - Latency is unchanged: correction is applied on the RUN→DONE load.
- `MULDIV_SIGNED_EN` undefined: `op[1]` is ignored and all operations are unsigned.

## Test plan
- Multiply 7 × 6 → `done` exactly 33 cycles after `start`; `resultHi`=0, `resultLo`=42; `busy` high for 33 cycles.
- Multiply 0xFFFFFFFF × 0xFFFFFFFF → `resultHi`=0xFFFFFFFE, `resultLo`=0x00000001 (carry path).
- Divide 100 / 7 → q=14, r=2. Divide 0xFFFFFFFF / 0x80000001 → q=1, r=0x7FFFFFFE (sh[32] path).
- Divide 5 / 0 → `resultLo`=0xFFFFFFFF, `resultHi`=5, same 33-cycle latency.
- `start` pulsed at RUN cycle 10 → ignored, results unchanged. `rst` at RUN cycle 20 → `busy`=0 next cycle, no `done`, results 0.
- With `MULDIV_SIGNED_EN`: signed −7 / 2 → q=0xFFFFFFFD, r=0xFFFFFFFF; signed −3 × 4 → `resultHi`=0xFFFFFFFF, `resultLo`=0xFFFFFFF4.
